alu_sequencer: RTL and testbench

//  Multi-cycle execute stage directly upstream of the 4-entry register file (r0,r1,r2,eflags).

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle execute stage driving a 4-entry regfile through one reg_no/val/write_en port.
// Define ALU_FLAGS_WB_EN to write eflags after each ADD/SUB/AND/OR/XOR/ADDI result.
//
// state    | meaning
// IDLE     | waiting for an instruction, instr_ready high
// RD_A     | regfile addressed with rs1, opA captured at exit
// RD_B     | regfile addressed with rs2, opB captured at exit
// EXEC     | result and flags computed and captured at exit
// WB_RES   | result written to rd
// WB_FLG   | flags written to eflags
// DONE     | retire pulse (done, illegal)
module alu_sequencer #(
  parameter int DATA_W   = 4,
  parameter int FLAG_REG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [11:0]       instr,
  output logic              rf_write_en,
  output logic [3:0]        rf_reg_no,
  output logic [DATA_W-1:0] rf_val,
  input  logic [DATA_W-1:0] rf_dout,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB_RES, S_WB_FLG, S_DONE
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] FLAG_NO = 4'(FLAG_REG);
  localparam int         MSB     = DATA_W - 1;

  state_e            state_q, state_d;
  logic [11:0]       instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic [3:0]        op, in_op;
  logic [1:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic              is_alu3, is_addi, is_legal, writes_res, writes_flags, rd_is_flag;
  logic              in_reads_a;

  assign op    = instr_q[11:8];
  assign rd    = instr_q[7:6];
  assign rs1   = instr_q[5:4];
  assign rs2   = instr_q[1:0];
  assign imm   = DATA_W'(instr_q[3:0]);
  assign in_op = instr[11:8];

  assign is_alu3      = (op >= OP_ADD) && (op <= OP_XOR);
  assign is_addi      = (op == OP_ADDI);
  assign is_legal     = (op <= OP_ADDI);
  assign writes_res   = is_alu3 || is_addi || (op == OP_MOV) || (op == OP_LDI);
  assign writes_flags = is_alu3 || is_addi;
  assign rd_is_flag   = ({2'b00, rd} == FLAG_NO);
  assign in_reads_a   = ((in_op >= OP_ADD) && (in_op <= OP_MOV)) || (in_op == OP_ADDI);

  // ALU: operands are registered, so this settles well within the EXEC cycle.
  logic [DATA_W-1:0] alu_b, alu_res;
  logic [DATA_W:0]   sum, diff;
  logic              alu_c, alu_v;
  logic [3:0]        alu_flags;

  always_comb begin
    alu_b   = is_addi ? imm : opb_q;
    sum     = {1'b0, opa_q} + {1'b0, alu_b};
    diff    = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (opa_q[MSB] == alu_b[MSB]) && (alu_res[MSB] != opa_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[DATA_W];
        alu_v   = (opa_q[MSB] != opb_q[MSB]) && (alu_res[MSB] != opa_q[MSB]);
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_MOV:  alu_res = opa_q;
      OP_LDI:  alu_res = imm;
      default: alu_res = '0;
    endcase
    alu_flags = {alu_v, alu_res[MSB], alu_c, (alu_res == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = in_reads_a ? S_RD_A : S_EXEC;
        end
      end
      S_RD_A: begin
        opa_d   = rf_dout;
        state_d = is_alu3 ? S_RD_B : S_EXEC;
      end
      S_RD_B: begin
        opb_d   = rf_dout;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        flags_d  = alu_flags;
        state_d  = writes_res ? S_WB_RES : S_DONE;
      end
      S_WB_RES: begin
`ifdef ALU_FLAGS_WB_EN
        // An explicit write to eflags must not be overwritten by the flag write-back.
        state_d = (writes_flags && !rd_is_flag) ? S_WB_FLG : S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_WB_FLG: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    rf_write_en = 1'b0;
    rf_reg_no   = 4'd0;
    rf_val      = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_RD_A: rf_reg_no = {2'b00, rs1};
      S_RD_B: rf_reg_no = {2'b00, rs2};
      S_WB_RES: begin
        rf_reg_no   = {2'b00, rd};
        rf_val      = result_q;
        rf_write_en = 1'b1;
      end
      S_WB_FLG: begin
        rf_reg_no   = FLAG_NO;
        rf_val      = DATA_W'(flags_q);
        rf_write_en = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = !is_legal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a negedge-writing regfile model; tracks ALU_FLAGS_WB_EN.
module tb_alu_sequencer;

`ifdef ALU_FLAGS_WB_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic        rf_write_en;
  logic [3:0]  rf_reg_no;
  logic [3:0]  rf_val;
  logic [3:0]  rf_dout;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [3:0]  rf [4];
  int          wr_count = 0;
  int          done_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_write_en (rf_write_en),
    .rf_reg_no   (rf_reg_no),
    .rf_val      (rf_val),
    .rf_dout     (rf_dout),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign rf_dout = (rf_reg_no < 4'd4) ? rf[rf_reg_no[1:0]] : 4'h0;

  always @(negedge clk) begin
    if (rf_write_en && (rf_reg_no < 4'd4)) begin
      rf[rf_reg_no[1:0]] = rf_val;
      wr_count++;
    end
    if (done) done_cnt++;
  end

  function automatic logic [11:0] enc(input int op, input int rd, input int rs1, input int imm);
    return {4'(op), 2'(rd), 2'(rs1), 4'(imm)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from IDLE and check retire latency, illegal flag, write count, single done.
  task automatic issue(input string tag, input logic [11:0] ins, input int exp_lat,
                       input int exp_wr, input logic exp_ill);
    int lat;
    int w0;
    int d0;
    logic ill;
    lat = 0;
    ill = 1'b0;
    check({tag, " ready"}, 16'(instr_ready), 16'd1);
    w0 = wr_count;
    d0 = done_cnt;
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 12'hFFF;
    for (int i = 1; i <= 12; i++) begin
      if (done) begin
        lat = i;
        ill = illegal;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " illegal"}, 16'(ill), 16'(exp_ill));
    @(posedge clk); #1;
    check({tag, " idle after"}, 16'(busy), 16'd0);
    check({tag, " writes"}, 16'(wr_count - w0), 16'(exp_wr));
    check({tag, " done pulses"}, 16'(done_cnt - d0), 16'd1);
  endtask

  initial begin
    int hit;
    int w0;
    int d0;
    for (int i = 0; i < 4; i++) rf[i] = 4'h0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 12'h000;
    #1;
    check("in reset write_en", 16'(rf_write_en), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset ready", 16'(instr_ready), 16'd1);
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset illegal", 16'(illegal), 16'd0);
    check("reset write_en", 16'(rf_write_en), 16'd0);
    check("reset reg_no", 16'(rf_reg_no), 16'd0);
    check("reset val", 16'(rf_val), 16'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("idle write_en", 16'(rf_write_en), 16'd0);
    end
    check("idle no writes", 16'(wr_count), 16'd0);

    issue("ldi r0,7", enc(7, 0, 0, 7), 3, 1, 1'b0);
    issue("ldi r1,9", enc(7, 1, 0, 9), 3, 1, 1'b0);
    check("r0=7", 16'(rf[0]), 16'h7);
    check("r1=9", 16'(rf[1]), 16'h9);
    issue("add r2,r0,r1", enc(1, 2, 0, 1), FW ? 6 : 5, FW ? 2 : 1, 1'b0);
    check("add r2", 16'(rf[2]), 16'h0);
    check("add eflags", 16'(rf[3]), FW ? 16'h3 : 16'h0);

    issue("ldi r0,3", enc(7, 0, 0, 3), 3, 1, 1'b0);
    issue("ldi r1,5", enc(7, 1, 0, 5), 3, 1, 1'b0);
    issue("sub r2,r0,r1", enc(2, 2, 0, 1), FW ? 6 : 5, FW ? 2 : 1, 1'b0);
    check("sub r2", 16'(rf[2]), 16'hE);
    check("sub eflags", 16'(rf[3]), FW ? 16'h6 : 16'h0);

    issue("ldi r0,7b", enc(7, 0, 0, 7), 3, 1, 1'b0);
    issue("addi r1,r0,1", enc(8, 1, 0, 1), FW ? 5 : 4, FW ? 2 : 1, 1'b0);
    check("addi r1", 16'(rf[1]), 16'h8);
    check("addi eflags", 16'(rf[3]), FW ? 16'hC : 16'h0);
    issue("mov r3,r1", enc(6, 3, 1, 0), 4, 1, 1'b0);
    check("mov eflags", 16'(rf[3]), 16'h8);

    issue("and r2,r0,r1", enc(3, 2, 0, 1), FW ? 6 : 5, FW ? 2 : 1, 1'b0);
    check("and r2", 16'(rf[2]), 16'h0);
    check("and eflags", 16'(rf[3]), FW ? 16'h1 : 16'h8);
    issue("xor r0,r0,r1", enc(5, 0, 0, 1), FW ? 6 : 5, FW ? 2 : 1, 1'b0);
    check("xor r0", 16'(rf[0]), 16'hF);
    check("xor eflags", 16'(rf[3]), FW ? 16'h4 : 16'h8);
    issue("or r2,r3,r1", enc(4, 2, 3, 1), FW ? 6 : 5, FW ? 2 : 1, 1'b0);
    check("or r2 reads eflags", 16'(rf[2]), FW ? 16'hC : 16'h8);
    check("or eflags", 16'(rf[3]), FW ? 16'h4 : 16'h8);
    issue("add r3,r0,r1", enc(1, 3, 0, 1), 5, 1, 1'b0);
    check("add to eflags", 16'(rf[3]), 16'h7);

    issue("nop", enc(0, 2, 1, 3), 2, 0, 1'b0);
    issue("illegal op B", enc(11, 1, 2, 3), 2, 0, 1'b1);
    check("illegal leaves r1", 16'(rf[1]), 16'h8);

    // Reset during the result write-back of an ADD.
    instr = enc(1, 2, 0, 1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 8; i++) begin
      if (rf_write_en) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid-op wb_res reached", 16'(hit), 16'd1);
    check("mid-op wb_res reg_no", 16'(rf_reg_no), 16'd2);
    d0 = done_cnt;
    w0 = wr_count;
    rst = 1'b1;
    #1;
    check("mid-op rst write_en", 16'(rf_write_en), 16'd0);
    check("mid-op rst busy", 16'(busy), 16'd0);
    check("mid-op rst ready", 16'(instr_ready), 16'd1);
    check("mid-op rst done", 16'(done), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid-op no done", 16'(done_cnt - d0), 16'd0);
    check("mid-op no write", 16'(wr_count - w0), 16'd0);
    check("mid-op r2 kept", 16'(rf[2]), FW ? 16'hC : 16'h8);
    issue("ldi r1,2 after rst", enc(7, 1, 0, 2), 3, 1, 1'b0);
    check("recovery r1", 16'(rf[1]), 16'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
